// File: rtl/interrupt_ctrl.sv
// interrupt_ctrl: coprocessor-0 style interrupt controller.
// Holds Status (IM/EXL/IE), a live Cause view and EPC. It decides each cycle
// whether the core takes an interrupt and supplies the handler address to the
// PC mux.
//
// Ports:
//   clock, reset              rising-edge clock, synchronous active-high reset
//   wr_data, regnum, MTC0     CP0 register write (12=Status, 13=Cause, 14=EPC)
//   ERET                      return from handler
//   next_pc                   PC saved into EPC on interrupt entry
//   TimerInterrupt, ext_irq   level interrupt sources (IP7, IP6..IP2)
//   rd_data                   MFC0 read data for regnum (combinational)
//   EPC                       registered exception PC
//   handler_pc                constant handler entry address
//   TakenInterrupt            interrupt taken this cycle (combinational)
//   ExceptionLevel            Status.EXL
//
// FSM (state is Status.EXL):
//   state   | meaning
//   RUN     | EXL=0, normal execution, interrupts may be taken
//   HANDLER | EXL=1, in handler, interrupts masked until ERET
module interrupt_ctrl #(
  parameter logic [31:0] HANDLER_ADDR = 32'h80000180,
  parameter logic [31:0] STATUS_RESET = 32'h00000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] wr_data,
  input  logic [4:0]  regnum,
  input  logic        MTC0,
  input  logic        ERET,
  input  logic [31:0] next_pc,
  input  logic        TimerInterrupt,
  input  logic [4:0]  ext_irq,
  output logic [31:0] rd_data,
  output logic [31:0] EPC,
  output logic [31:0] handler_pc,
  output logic        TakenInterrupt,
  output logic        ExceptionLevel
);

  localparam logic [4:0] REG_STATUS = 5'd12;
  localparam logic [4:0] REG_CAUSE  = 5'd13;
  localparam logic [4:0] REG_EPC    = 5'd14;

  logic [7:0]  im_q, im_d;
  logic        ie_q, ie_d;
  logic        exl_q, exl_d;
  logic [31:0] epc_q, epc_d;

  logic [31:0] status_w;
  logic [31:0] cause_w;
  logic        pending_w;
  logic        take_w;

  assign status_w  = {16'h0, im_q, 6'h0, exl_q, ie_q};
  assign cause_w   = {16'h0, TimerInterrupt, ext_irq, 10'h0};
  // Only IP7..IP2 exist; IM[1:0] (software interrupts) have no source.
  assign pending_w = |(cause_w[15:10] & status_w[15:10]);
  assign take_w    = pending_w & ie_q & ~exl_q;

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      im_q  <= STATUS_RESET[15:8];
      exl_q <= STATUS_RESET[1];
      ie_q  <= STATUS_RESET[0];
      epc_q <= 32'h0;
    end else begin
      im_q  <= im_d;
      exl_q <= exl_d;
      ie_q  <= ie_d;
      epc_q <= epc_d;
    end
  end

  // Next-state logic. Software writes are applied first; interrupt entry
  // and ERET then override EXL (and entry overrides EPC).
  always_comb begin
    im_d  = im_q;
    ie_d  = ie_q;
    exl_d = exl_q;
    epc_d = epc_q;
    if (MTC0 && regnum == REG_STATUS) begin
      im_d  = wr_data[15:8];
      exl_d = wr_data[1];
      ie_d  = wr_data[0];
    end
    if (MTC0 && regnum == REG_EPC) begin
      epc_d = wr_data;
    end
    if (take_w) begin
      exl_d = 1'b1;
      epc_d = next_pc;
    end else if (ERET && exl_q) begin
      exl_d = 1'b0;
    end
  end

  // Outputs
  always_comb begin
    rd_data = 32'h0;
    case (regnum)
      REG_STATUS: rd_data = status_w;
      REG_CAUSE:  rd_data = cause_w;
      REG_EPC:    rd_data = epc_q;
      default:    rd_data = 32'h0;
    endcase
    EPC            = epc_q;
    handler_pc     = HANDLER_ADDR;
    TakenInterrupt = take_w;
    ExceptionLevel = exl_q;
  end

endmodule

// File: tb/tb_interrupt_ctrl.sv
module tb_interrupt_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] wr_data;
  logic [4:0]  regnum;
  logic        MTC0;
  logic        ERET;
  logic [31:0] next_pc;
  logic        TimerInterrupt;
  logic [4:0]  ext_irq;
  logic [31:0] rd_data;
  logic [31:0] EPC;
  logic [31:0] handler_pc;
  logic        TakenInterrupt;
  logic        ExceptionLevel;

  interrupt_ctrl dut (
    .clock          (clock),
    .reset          (reset),
    .wr_data        (wr_data),
    .regnum         (regnum),
    .MTC0           (MTC0),
    .ERET           (ERET),
    .next_pc        (next_pc),
    .TimerInterrupt (TimerInterrupt),
    .ext_irq        (ext_irq),
    .rd_data        (rd_data),
    .EPC            (EPC),
    .handler_pc     (handler_pc),
    .TakenInterrupt (TakenInterrupt),
    .ExceptionLevel (ExceptionLevel)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rst;
    logic        mtc0;
    logic [4:0]  rn;
    logic [31:0] wd;
    logic        eret;
    logic [31:0] npc;
    logic        tmr;
    logic [4:0]  ext;
    logic        e_take;
    logic        e_exl;
    logic [31:0] e_epc;
    logic [31:0] e_rd;
  } vec_t;

  vec_t vecs[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  function automatic vec_t mk(logic rst, logic mtc0, logic [4:0] rn, logic [31:0] wd,
                              logic eret, logic [31:0] npc, logic tmr, logic [4:0] ext,
                              logic e_take, logic e_exl, logic [31:0] e_epc,
                              logic [31:0] e_rd);
    vec_t v;
    v.rst = rst; v.mtc0 = mtc0; v.rn = rn; v.wd = wd; v.eret = eret; v.npc = npc;
    v.tmr = tmr; v.ext = ext; v.e_take = e_take; v.e_exl = e_exl; v.e_epc = e_epc;
    v.e_rd = e_rd;
    return v;
  endfunction

  // Drive inputs just after a rising edge, check before the next one, then
  // let the edge commit the vector.
  task automatic apply(input vec_t v, input int idx);
    reset          = v.rst;
    MTC0           = v.mtc0;
    regnum         = v.rn;
    wr_data        = v.wd;
    ERET           = v.eret;
    next_pc        = v.npc;
    TimerInterrupt = v.tmr;
    ext_irq        = v.ext;
    @(negedge clock);
    n_vec++;
    if (TakenInterrupt !== v.e_take) begin
      n_miss++;
      $display("FAIL vec%0d take: got %b want %b", idx, TakenInterrupt, v.e_take);
    end
    if (ExceptionLevel !== v.e_exl) begin
      n_miss++;
      $display("FAIL vec%0d exl: got %b want %b", idx, ExceptionLevel, v.e_exl);
    end
    if (EPC !== v.e_epc) begin
      n_miss++;
      $display("FAIL vec%0d epc: got %h want %h", idx, EPC, v.e_epc);
    end
    if (rd_data !== v.e_rd) begin
      n_miss++;
      $display("FAIL vec%0d rd_data(%0d): got %h want %h", idx, v.rn, rd_data, v.e_rd);
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    //         rst mtc rn  wd            eret npc           tmr ext       take exl epc           rd
    // reset, timer with Status=0
    vecs.push_back(mk(0, 0, 13, 32'h0,        0, 32'h0,        1, 5'b00000, 0, 0, 32'h0,        32'h00008000));
    vecs.push_back(mk(0, 0, 12, 32'h0,        0, 32'h0,        1, 5'b00000, 0, 0, 32'h0,        32'h0));
    vecs.push_back(mk(0, 0, 13, 32'h0,        0, 32'h0,        1, 5'b11111, 0, 0, 32'h0,        32'h0000FC00));
    // enable IP7 + IE, then take
    vecs.push_back(mk(0, 1, 12, 32'h00008001, 0, 32'h0,        1, 5'b00000, 0, 0, 32'h0,        32'h0));
    vecs.push_back(mk(0, 0, 12, 32'h0,        0, 32'h00400024, 1, 5'b00000, 1, 0, 32'h0,        32'h00008001));
    vecs.push_back(mk(0, 0, 12, 32'h0,        0, 32'h0,        1, 5'b00000, 0, 1, 32'h00400024, 32'h00008003));
    // handler masks timer for several cycles
    vecs.push_back(mk(0, 0, 14, 32'h0,        0, 32'h0,        1, 5'b00000, 0, 1, 32'h00400024, 32'h00400024));
    vecs.push_back(mk(0, 0, 14, 32'h0,        0, 32'h0,        1, 5'b00000, 0, 1, 32'h00400024, 32'h00400024));
    vecs.push_back(mk(0, 0, 14, 32'h0,        0, 32'h0,        1, 5'b00000, 0, 1, 32'h00400024, 32'h00400024));
    vecs.push_back(mk(0, 0, 14, 32'h0,        0, 32'h0,        1, 5'b00000, 0, 1, 32'h00400024, 32'h00400024));
    // drop timer, ERET, no retake
    vecs.push_back(mk(0, 0, 12, 32'h0,        1, 32'h0,        0, 5'b00000, 0, 1, 32'h00400024, 32'h00008003));
    vecs.push_back(mk(0, 0, 12, 32'h0,        0, 32'h0,        0, 5'b00000, 0, 0, 32'h00400024, 32'h00008001));
    vecs.push_back(mk(0, 0, 12, 32'h0,        0, 32'h0,        0, 5'b00000, 0, 0, 32'h00400024, 32'h00008001));
    // ERET with timer still high -> retake the cycle after
    vecs.push_back(mk(0, 0, 14, 32'h0,        0, 32'h00400040, 1, 5'b00000, 1, 0, 32'h00400024, 32'h00400024));
    vecs.push_back(mk(0, 0, 14, 32'h0,        1, 32'h00400050, 1, 5'b00000, 0, 1, 32'h00400040, 32'h00400040));
    vecs.push_back(mk(0, 0, 14, 32'h0,        0, 32'h00400060, 1, 5'b00000, 1, 0, 32'h00400040, 32'h00400040));
    vecs.push_back(mk(0, 0, 14, 32'h0,        0, 32'h0,        1, 5'b00000, 0, 1, 32'h00400060, 32'h00400060));
    // ERET + MTC0 Status (wd sets EXL, ERET wins): IM=04, IE=1
    vecs.push_back(mk(0, 1, 12, 32'h00000403, 1, 32'h0,        0, 5'b00000, 0, 1, 32'h00400060, 32'h00008003));
    vecs.push_back(mk(0, 0, 12, 32'h0,        0, 32'h0,        0, 5'b00010, 0, 0, 32'h00400060, 32'h00000401));
    // IP2 take with simultaneous MTC0 EPC: entry wins
    vecs.push_back(mk(0, 1, 14, 32'hDEADBEEF, 0, 32'h00400080, 0, 5'b00001, 1, 0, 32'h00400060, 32'h00400060));
    vecs.push_back(mk(0, 0, 14, 32'h0,        0, 32'h0,        0, 5'b00001, 0, 1, 32'h00400080, 32'h00400080));
    vecs.push_back(mk(0, 0, 12, 32'h0,        1, 32'h0,        0, 5'b00000, 0, 1, 32'h00400080, 32'h00000403));
    // take + MTC0 Status clearing IE/EXL: EXL forced to 1, IE cleared
    vecs.push_back(mk(0, 1, 12, 32'h00000400, 0, 32'h004000A0, 0, 5'b00001, 1, 0, 32'h00400080, 32'h00000401));
    vecs.push_back(mk(0, 0, 12, 32'h0,        0, 32'h0,        0, 5'b00001, 0, 1, 32'h004000A0, 32'h00000402));
    // software clears EXL and sets IE; take honoured the next cycle
    vecs.push_back(mk(0, 1, 12, 32'h00000401, 0, 32'h0,        0, 5'b00001, 0, 1, 32'h004000A0, 32'h00000402));
    vecs.push_back(mk(0, 0, 12, 32'h0,        0, 32'h004000C0, 0, 5'b00001, 1, 0, 32'h004000A0, 32'h00000401));
    // MTC0 EPC in handler, then ERET + MTC0 EPC
    vecs.push_back(mk(0, 1, 14, 32'h12345678, 0, 32'h0,        0, 5'b00000, 0, 1, 32'h004000C0, 32'h004000C0));
    vecs.push_back(mk(0, 1, 14, 32'h00400100, 1, 32'h0,        0, 5'b00000, 0, 1, 32'h12345678, 32'h12345678));
    // ERET in RUN: nothing changes
    vecs.push_back(mk(0, 0, 14, 32'h0,        1, 32'h0,        0, 5'b00000, 0, 0, 32'h00400100, 32'h00400100));
    // all-ones Status write: unimplemented bits dropped, EXL set by software
    vecs.push_back(mk(0, 1, 12, 32'hFFFFFFFF, 0, 32'h0,        1, 5'b00000, 0, 0, 32'h00400100, 32'h00000401));
    vecs.push_back(mk(0, 0, 12, 32'h0,        0, 32'h0,        1, 5'b00000, 0, 1, 32'h00400100, 32'h0000FF03));
    vecs.push_back(mk(0, 0, 5,  32'h0,        0, 32'h0,        1, 5'b00000, 0, 1, 32'h00400100, 32'h0));
    // reset in handler overrides a simultaneous MTC0 EPC
    vecs.push_back(mk(1, 1, 14, 32'hAAAA5555, 0, 32'h0,        1, 5'b00000, 0, 1, 32'h00400100, 32'h00400100));
    vecs.push_back(mk(0, 0, 12, 32'h0,        0, 32'h0,        1, 5'b00000, 0, 0, 32'h0,        32'h0));
    vecs.push_back(mk(0, 0, 13, 32'h0,        0, 32'h0,        1, 5'b10101, 0, 0, 32'h0,        32'h0000D400));
    vecs.push_back(mk(0, 0, 15, 32'h0,        0, 32'h0,        1, 5'b10101, 0, 0, 32'h0,        32'h0));

    reset = 1'b1; MTC0 = 1'b0; ERET = 1'b0; regnum = 5'd0; wr_data = 32'h0;
    next_pc = 32'h0; TimerInterrupt = 1'b0; ext_irq = 5'b0;
    repeat (2) @(posedge clock);
    #1;

    n_vec++;
    if (handler_pc !== 32'h80000180) begin
      n_miss++;
      $display("FAIL handler_pc: got %h want %h", handler_pc, 32'h80000180);
    end

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Hand sequence: reset in the very cycle an interrupt is being taken.
    apply(mk(0, 1, 12, 32'h00008001, 0, 32'h0,        0, 5'b00000, 0, 0, 32'h0, 32'h0), 100);
    apply(mk(1, 1, 14, 32'h11111111, 0, 32'h00400200, 1, 5'b00000, 1, 0, 32'h0, 32'h0), 101);
    apply(mk(0, 0, 12, 32'h0,        0, 32'h0,        1, 5'b00000, 0, 0, 32'h0, 32'h0), 102);
    // Hand sequence: ERET + MTC0 Status in the same cycle leaves EXL clear
    // and the new IE lets a pending source in on the next cycle.
    apply(mk(0, 1, 12, 32'h00008003, 0, 32'h0,        1, 5'b00000, 0, 0, 32'h0,          32'h0), 103);
    apply(mk(0, 1, 12, 32'h00008003, 1, 32'h00400300, 1, 5'b00000, 0, 1, 32'h0,          32'h00008003), 104);
    apply(mk(0, 0, 14, 32'h0,        0, 32'h00400310, 1, 5'b00000, 1, 0, 32'h0,          32'h0), 105);
    apply(mk(0, 0, 14, 32'h0,        0, 32'h0,        1, 5'b00000, 0, 1, 32'h00400310, 32'h00400310), 106);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/interrupt_ctrl.md
Name: interrupt_ctrl

Overview:
- Coprocessor-0 style interrupt controller that sits directly downstream of the MMIO timer.
- Consumes the timer's level-sensitive TimerInterrupt, plus five external interrupt lines, and holds the Status, Cause and EPC registers.
- Decides each cycle whether the core takes an interrupt, and supplies the datapath PC mux with the handler address on entry and the EPC on ERET.
- Software clears the timer source itself, through the timer acknowledge address, before ERET.

Parameters:
- HANDLER_ADDR, 32'h80000180, PC the datapath loads when TakenInterrupt is high.
- STATUS_RESET, 32'h00000000, reset value of the Status register (interrupts disabled).

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- wr_data  input  32  MTC0 source data.
- regnum  input  5  CP0 register number for MTC0/MFC0 (12=Status, 13=Cause, 14=EPC).
- MTC0  input  1  write wr_data to register regnum this cycle.
- ERET  input  1  return from handler this cycle.
- next_pc  input  32  address of the instruction after the one in the current cycle; saved to EPC on interrupt entry.
- TimerInterrupt  input  1  level interrupt from the timer; drives IP7 (Cause bit 15).
- ext_irq  input  5  external level interrupts; ext_irq[i] drives IP(2+i) (Cause bit 10+i).
- rd_data  output  32  MFC0 read data for regnum; combinational.
- EPC  output  32  registered exception PC.
- handler_pc  output  32  constant HANDLER_ADDR.
- TakenInterrupt  output  1  interrupt taken this cycle; combinational.
- ExceptionLevel  output  1  Status.EXL; high while in the handler.

Behaviour:
- Status (12):
  - Implemented fields: IM[15:8], EXL bit 1, IE bit 0. All other bits read 0, and writes to them are dropped.
- Cause (13):
  - IP[15:10] = {TimerInterrupt, ext_irq[4:0]}, reflected live (combinational, not latched).
  - ExcCode[6:2] = 0. All other bits 0.
  - Cause is read-only; MTC0 to 13 has no effect.
- EPC (14): 32-bit register, written by MTC0 or by interrupt entry.
- rd_data: selects Status, Cause or EPC by regnum; any other regnum reads 32'h0.
- pending = |(Cause[15:10] & Status[15:10]).
- TakenInterrupt = pending & IE & ~EXL, evaluated combinationally the same cycle.
- Two-state FSM, encoded by EXL:
  - RUN (EXL=0) -> HANDLER on TakenInterrupt. On that edge: EPC <= next_pc, EXL <= 1.
  - HANDLER (EXL=1) -> RUN on ERET. On that edge: EXL <= 0. EPC and IM/IE are unchanged.
- Latency:
  - PC mux switches to handler_pc in the same cycle TakenInterrupt is high.
  - EPC and ExceptionLevel reflect the entry from the next cycle onward.
- Interrupts are masked while EXL=1. During the ERET cycle EXL is still 1, so no take occurs.
- A source still pending and enabled after ERET is taken on the cycle immediately after ERET.
- ERET in RUN: no state change.
- Simultaneous events:
  - TakenInterrupt + MTC0 Status: IM/IE take wr_data, EXL is forced to 1.
  - TakenInterrupt + MTC0 EPC: entry wins, EPC <= next_pc.
  - ERET + MTC0 Status: IM/IE take wr_data, EXL <= 0.
  - ERET + MTC0 EPC: EPC takes wr_data.
- MTC0 to Status may set or clear EXL directly. TakenInterrupt honours the new value from the next cycle.
- Reset (including mid-handler):
  - Status <= STATUS_RESET, EPC <= 0, FSM -> RUN.
  - TakenInterrupt and ExceptionLevel read 0 in the cycle after reset, given the default STATUS_RESET.
  - Reset overrides every simultaneous MTC0, ERET or interrupt entry.

Test Plan:
- Reset, then TimerInterrupt=1 with Status=0 -> TakenInterrupt=0 for all cycles; rd_data(13)=32'h00008000; rd_data(12)=0.
- MTC0 Status=32'h00008001, TimerInterrupt=1, next_pc=32'h00400024 -> TakenInterrupt=1 that cycle; next cycle EPC=32'h00400024, ExceptionLevel=1, rd_data(12)=32'h00008003.
- In HANDLER, hold TimerInterrupt=1 for 5 cycles -> TakenInterrupt stays 0. Drop TimerInterrupt, then ERET -> EXL=0 next cycle, EPC unchanged, no retake.
- In HANDLER, ERET with TimerInterrupt still 1 -> TakenInterrupt=0 in the ERET cycle and 1 the cycle after; EPC reloads that cycle's next_pc.
- IM=8'h04 (IP2 only), ext_irq=5'b00010 -> no take. Then ext_irq=5'b00001 with IE=1 -> take. Same cycle MTC0 EPC=32'hDEADBEEF -> EPC=next_pc, not 32'hDEADBEEF.
- Reset asserted in HANDLER with EPC=32'h00400100 -> next cycle EXL=0, EPC=0, rd_data(12)=0, TakenInterrupt=0 despite TimerInterrupt=1.
